// File: rtl/pipe_skid_stage_pkg.sv
// Shared constants for the elastic pipeline stages: payload widths,
// occupancy encodings and NOP payloads used as bubbles.
package pipe_skid_stage_pkg;

  // Per-stage payload widths
  localparam int IF_ID_W  = 64;   // pc 32 + inst 32
  localparam int ID_EX_W  = 119;  // aluop 8 + alusel 3 + 2x reg 32 + wreg 1 + waddr 5 + link 32 + spare 6
  localparam int EX_MEM_W = 38;   // wdata 32 + waddr 5 + wreg 1

  // Occupancy doubles as the state encoding
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // NOP field encodings
  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [2:0] EXE_RES_NOP = 3'b000;
  localparam logic [4:0] NOPRegAddr  = 5'b00000;

  // NOP payloads, field order matches the width breakdown above
  localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = '0;
  localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = {EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0,
                                                1'b0, NOPRegAddr, 32'h0, 6'h0};
  localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = {32'h0, NOPRegAddr, 1'b0};

endpackage

// File: rtl/pipe_sat_cnt.sv
// 32-bit saturating event counter with enable and synchronous clear.
module pipe_sat_cnt (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] cnt
);

  logic [31:0] cnt_d, cnt_q;

  // Next count: clear wins, otherwise step until all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                       cnt_d = '0;
    else if (en && (cnt_q != '1))  cnt_d = cnt_q + 32'd1;
  end

  // Count register
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline register with a two-entry (main + skid)
// buffer so in_ready is registered and still sustains one transfer/cycle.
// Optional perf counters enabled by defining PIPE_SKID_PERF_CNT_EN.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                DATA_W   = ID_EX_W,
  parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_SKID_PERF_CNT_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
`endif
  output logic [1:0]        occupancy
);

  skid_state_e       state_d, state_q;
  logic [DATA_W-1:0] main_d, main_q;
  logic [DATA_W-1:0] skid_d, skid_q;
  logic              in_ready_d, in_ready_q;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = (state_q != SKID_EMPTY) & out_ready;

  // Next-state and buffer updates; flush overrides every handshake
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = SKID_EMPTY;
      main_d  = NOP_DATA;
      skid_d  = NOP_DATA;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (in_fire) begin
            state_d = SKID_ONE;
            main_d  = in_data;
          end
        end
        SKID_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = SKID_TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = SKID_EMPTY;
            main_d  = NOP_DATA;
          end
        end
        SKID_TWO: begin
          // in_ready is low here, so only the drain side can move
          if (out_fire) begin
            state_d = SKID_ONE;
            main_d  = skid_q;
            skid_d  = NOP_DATA;
          end
        end
        default: begin
          state_d = SKID_EMPTY;
          main_d  = NOP_DATA;
          skid_d  = NOP_DATA;
        end
      endcase
    end
    // Registered ready: low exactly while both entries are held
    in_ready_d = (state_d != SKID_TWO);
  end

  // State, buffer and ready registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SKID_EMPTY;
      main_q     <= NOP_DATA;
      skid_q     <= NOP_DATA;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = main_q;   // main is NOP_DATA whenever empty
  assign occupancy = state_q;

`ifdef PIPE_SKID_PERF_CNT_EN
  // Cycles stalled by downstream and cycles presenting a bubble
  pipe_sat_cnt u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

  pipe_sat_cnt u_bubble_cnt (
    .clk (clk),
    .clr (rst),
    .en  (~out_valid & ~rst),
    .cnt (bubble_cnt)
  );
`endif

endmodule
